// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encodings and CMP result bit positions shared by the ALU pipeline.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
//
// Used by alu_pipe (top) and alu_pipe_core (datapath) via import alu_pipe_pkg::*.
package alu_pipe_pkg;

  localparam logic [2:0] OP_ADD_RCA = 3'b000;
  localparam logic [2:0] OP_ADD_CLA = 3'b001;
  localparam logic [2:0] OP_ADD_CSA = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_INC     = 3'b100;
  localparam logic [2:0] OP_DEC     = 3'b101;
  localparam logic [2:0] OP_CMP     = 3'b110;
  localparam logic [2:0] OP_PASS    = 3'b111;

  // Bit positions inside y for a CMP result; all other bits are zero.
  localparam int CMP_EQ_BIT = 0;
  localparam int CMP_GT_BIT = 1;
  localparam int CMP_LT_BIT = 2;

  // Ops whose carry-in may come from the stored carry and whose carry-out updates it.
  function automatic logic is_addsub(input logic [2:0] op);
    return (op == OP_ADD_RCA) || (op == OP_ADD_CLA) ||
           (op == OP_ADD_CSA) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational ALU datapath (three adder structures + result/flag formation).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
//
// Ports: a, b (WIDTH operands), op (3-bit opcode), cin (carry-in for ADD*/SUB)
//        -> y (WIDTH result), cout, zero, neg, ovf.
// Also holds the adder building blocks alu_pipe_rca, alu_pipe_cla, alu_pipe_csa.

// Ripple-carry adder: one full adder per bit, carry walked LSB to MSB.
module alu_pipe_rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic carry;

  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  assign cout = carry;
endmodule

// Carry-lookahead adder: every carry is the flattened sum-of-products of
// generate/propagate terms, so no carry depends on a neighbouring carry.
module alu_pipe_cla #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             carry_acc;
  logic             prop_acc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c         = '0;
    carry_acc = 1'b0;
    prop_acc  = 1'b0;
    c[0]      = cin;
    for (int i = 0; i < WIDTH; i++) begin
      // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
      carry_acc = g[i];
      prop_acc  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry_acc = carry_acc | (prop_acc & g[j]);
        prop_acc  = prop_acc & p[j];
      end
      c[i+1] = carry_acc | (prop_acc & cin);
    end
  end

  assign s    = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];
endmodule

// Carry-select adder: upper half computed for both carry-in values in
// parallel with the lower half, then picked by the lower half's carry.
module alu_pipe_csa #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic [LO-1:0] s_lo;
  logic [HI-1:0] s_hi0;
  logic [HI-1:0] s_hi1;
  logic          c_lo;
  logic          c_hi0;
  logic          c_hi1;

  alu_pipe_rca #(.WIDTH(LO)) u_lo (
    .a(a[LO-1:0]), .b(b[LO-1:0]), .cin(cin), .s(s_lo), .cout(c_lo)
  );
  alu_pipe_rca #(.WIDTH(HI)) u_hi0 (
    .a(a[WIDTH-1:LO]), .b(b[WIDTH-1:LO]), .cin(1'b0), .s(s_hi0), .cout(c_hi0)
  );
  alu_pipe_rca #(.WIDTH(HI)) u_hi1 (
    .a(a[WIDTH-1:LO]), .b(b[WIDTH-1:LO]), .cin(1'b1), .s(s_hi1), .cout(c_hi1)
  );

  assign s    = {(c_lo ? s_hi1 : s_hi0), s_lo};
  assign cout = c_lo ? c_hi1 : c_hi0;
endmodule

module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  logic [WIDTH-1:0] opb;      // second adder operand after op-specific transform
  logic             acin;     // adder carry-in after op-specific selection
  logic [WIDTH-1:0] s_rca, s_cla, s_csa, sum;
  logic             c_rca, c_cla, c_csa, carry;
  logic             add_ovf;
  logic [WIDTH-1:0] flag_src; // value zero/neg are derived from (d for CMP, y otherwise)

  // Every op is folded onto a single a + opb + acin addition.
  always_comb begin
    opb  = '0;
    acin = 1'b0;
    case (op)
      OP_ADD_RCA, OP_ADD_CLA, OP_ADD_CSA: begin opb = b;  acin = cin;  end
      OP_SUB:                             begin opb = ~b; acin = cin;  end
      OP_CMP:                             begin opb = ~b; acin = 1'b1; end
      OP_INC:                             begin opb = '0; acin = 1'b1; end
      OP_DEC:                             begin opb = '1; acin = 1'b0; end
      default:                            begin opb = '0; acin = 1'b0; end
    endcase
  end

  alu_pipe_rca #(.WIDTH(WIDTH)) u_rca (.a(a), .b(opb), .cin(acin), .s(s_rca), .cout(c_rca));
  alu_pipe_cla #(.WIDTH(WIDTH)) u_cla (.a(a), .b(opb), .cin(acin), .s(s_cla), .cout(c_cla));
  alu_pipe_csa #(.WIDTH(WIDTH)) u_csa (.a(a), .b(opb), .cin(acin), .s(s_csa), .cout(c_csa));

  // Non-ADD ops go through the ripple adder; the structures are interchangeable.
  always_comb begin
    case (op)
      OP_ADD_CLA: begin sum = s_cla; carry = c_cla; end
      OP_ADD_CSA: begin sum = s_csa; carry = c_csa; end
      default:    begin sum = s_rca; carry = c_rca; end
    endcase
  end

  // Signed overflow: operands share a sign that the sum does not.
  assign add_ovf = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    y        = sum;
    cout     = carry;
    ovf      = add_ovf;
    flag_src = sum;
    case (op)
      OP_CMP: begin
        y             = '0;
        y[CMP_EQ_BIT] = (sum == '0);
        y[CMP_GT_BIT] = carry && (sum != '0);
        y[CMP_LT_BIT] = !carry;
      end
      OP_PASS: begin
        y        = a;
        cout     = 1'b0;
        ovf      = 1'b0;
        flag_src = a;
      end
      default: ;
    endcase
  end

  assign zero = (flag_src == '0);
  assign neg  = flag_src[WIDTH-1];
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU (operand register, then compute + result register).
// Latency: result valid two cycles after the op is presented; 1 op/cycle throughput.
// Backpressure: valid/ready both sides; stalled results held stable, in_ready drops only when both stages are full.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, op, chain (input side);
//        out_valid/out_ready, y, cout, zero, neg, ovf (output side).
// Build option: define ALU_PIPE_CHAIN_EN to add the stored-carry register that chain selects
// as carry-in for ADD*/SUB; without it chain is ignored.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_adv;    // output stage can take a new value this cycle
  logic             core_cin;
  logic [WIDTH-1:0] core_y;
  logic             core_cout, core_zero, core_neg, core_ovf;

  assign s2_adv   = !out_valid || out_ready;
  // Equivalent to !(s1_valid && out_valid && !out_ready), forced low during reset.
  assign in_ready = !rst && (!s1_valid || s2_adv);

`ifdef ALU_PIPE_CHAIN_EN
  logic s1_chain;
  logic cflag;

  always_comb begin
    if (s1_chain && is_addsub(s1_op)) core_cin = cflag;
    else                              core_cin = (s1_op == OP_SUB);
  end

  // Updated when the op is computed (s1 -> s2), so a chained op right behind
  // its partner already sees the fresh carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cflag <= 1'b0;
    end else if (s1_valid && s2_adv && is_addsub(s1_op)) begin
      cflag <= core_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) s1_chain <= chain;
  end
`else
  logic chain_unused;
  assign chain_unused = chain;
  assign core_cin     = (s1_op == OP_SUB);
`endif

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a    (s1_a),
    .b    (s1_b),
    .op   (s1_op),
    .cin  (core_cin),
    .y    (core_y),
    .cout (core_cout),
    .zero (core_zero),
    .neg  (core_neg),
    .ovf  (core_ovf)
  );

  // Operand datapath needs no reset; s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_a  <= a;
      s1_b  <= b;
      s1_op <= op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          y    <= core_y;
          cout <= core_cout;
          zero <= core_zero;
          neg  <= core_neg;
          ovf  <= core_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=8) with an arithmetic reference model.
// Latency: n/a.
// Backpressure: drives random and directed out_ready stalls.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 8;
`ifdef ALU_PIPE_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'd0;
  logic         chain = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         cout, zero, neg, ovf;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .chain(chain),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result vector {y, cout, zero, neg, ovf}
  typedef logic [W+3:0] res_t;
  res_t q[$];
  logic m_cflag = 1'b0;

  // Reference: plain integer arithmetic on unsigned and signed operand values.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [2:0] mop, input logic mch);
    int M = 1 << W;
    int H = 1 << (W - 1);
    int ua, ub, sa, sb, d, sr, cin;
    logic use_c;
    logic rc, rv;
    logic [W-1:0] ry, fsrc;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= H) ? ua - M : ua;
    sb = (ub >= H) ? ub - M : ub;
    use_c = mch && CHAIN_ON;
    d = ua; sr = 0; rc = 1'b0;
    case (mop)
      OP_ADD_RCA, OP_ADD_CLA, OP_ADD_CSA: begin
        cin = use_c ? int'(m_cflag) : 0;
        d = ua + ub + cin; rc = (d >= M); sr = sa + sb + cin;
        m_cflag = rc;
      end
      OP_SUB: begin
        cin = use_c ? int'(m_cflag) : 1;
        d = ua - ub - (1 - cin); rc = (d >= 0); sr = sa - sb - (1 - cin);
        m_cflag = rc;
      end
      OP_INC: begin d = ua + 1; rc = (ua == M - 1); sr = sa + 1; end
      OP_DEC: begin d = ua - 1; rc = (ua != 0);     sr = sa - 1; end
      OP_CMP: begin d = ua - ub; rc = (d >= 0);     sr = sa - sb; end
      default: begin d = ua; rc = 1'b0; sr = 0; end
    endcase
    ry   = d[W-1:0];
    fsrc = ry;
    rv   = (mop != OP_PASS) && ((sr < -H) || (sr > H - 1));
    if (mop == OP_CMP) begin
      ry = '0;
      ry[0] = (ua == ub);
      ry[1] = (ua > ub);
      ry[2] = (ua < ub);
    end
    return {ry, rc, (fsrc == '0), fsrc[W-1], rv};
  endfunction

  // Scoreboard: input transfers push model results, output transfers pop and compare.
  logic held = 1'b0;
  res_t held_vec;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cflag = 1'b0;
      held = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", 1, 0);
        else check("result", {y, cout, zero, neg, ovf}, q.pop_front());
      end
      if (out_valid && !out_ready) begin
        if (held) check("hold", {y, cout, zero, neg, ovf}, held_vec);
        held = 1'b1;
        held_vec = {y, cout, zero, neg, ovf};
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, op, chain));
    end
  end

  // One op into an idle pipe with out_ready=1; call at posedge+1.
  task automatic run_single(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic [2:0] top, input logic tch,
                            input logic [W-1:0] ey, input logic ec);
    a = ta; b = tb; op = top; chain = tch; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, out_valid, 1);
    check({tag, "_y"}, y, ey);
    check({tag, "_cout"}, cout, ec);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] bp_a [4];
  logic [W-1:0] bp_b [4];
  logic [2:0]   bp_op [4];

  task automatic load_bp(input int i);
    a = bp_a[i]; b = bp_b[i]; op = bp_op[i]; chain = 1'b0;
  endtask

  initial begin
    int idx;
    int guard;
    logic acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", {cout, zero, neg, ovf}, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed ops
    run_single("add_rca", 8'h3C, 8'h27, OP_ADD_RCA, 1'b0, 8'h63, 1'b0);
    run_single("add_csa", 8'hB5, 8'h6E, OP_ADD_CSA, 1'b0, 8'h23, 1'b1);
    run_single("add_cla", 8'hB5, 8'h6E, OP_ADD_CLA, 1'b0, 8'h23, 1'b1);
    run_single("inc_ff",  8'hFF, 8'h00, OP_INC,     1'b0, 8'h00, 1'b1);
    run_single("dec_00",  8'h00, 8'h00, OP_DEC,     1'b0, 8'hFF, 1'b0);
    run_single("add_ovf", 8'h7F, 8'h01, OP_ADD_RCA, 1'b0, 8'h80, 1'b0);
    run_single("cmp_gt",  8'h40, 8'h20, OP_CMP,     1'b0, 8'h02, 1'b1);
    run_single("cmp_eq",  8'h20, 8'h20, OP_CMP,     1'b0, 8'h01, 1'b1);
    run_single("cmp_lt",  8'h10, 8'h20, OP_CMP,     1'b0, 8'h04, 1'b0);
    run_single("pass",    8'hAA, 8'h55, OP_PASS,    1'b0, 8'hAA, 1'b0);
    run_single("sub",     8'h50, 8'h20, OP_SUB,     1'b0, 8'h30, 1'b1);

    // Multi-word add / subtract
    run_single("chain_add_lo", 8'hFF, 8'h01, OP_ADD_RCA, 1'b0, 8'h00, 1'b1);
    run_single("chain_add_hi", 8'h12, 8'h00, OP_ADD_CLA, 1'b1, CHAIN_ON ? 8'h13 : 8'h12, 1'b0);
    run_single("chain_sub_lo", 8'h00, 8'h01, OP_SUB,     1'b0, 8'hFF, 1'b0);
    run_single("chain_sub_hi", 8'h01, 8'h00, OP_SUB,     1'b1, CHAIN_ON ? 8'h00 : 8'h01, 1'b1);

    // Backpressure: 4 back-to-back ops against a stalled consumer
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = W'($urandom); bp_b[i] = W'($urandom); bp_op[i] = 3'($urandom_range(0, 7));
    end
    out_ready = 1'b0;
    idx = 0;
    load_bp(0);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) load_bp(idx); else in_valid = 1'b0;
      end
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    guard = 0;
    while (idx < 4 && guard < 20) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) load_bp(idx); else in_valid = 1'b0;
      end
      guard++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", idx, 4);
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", q.size(), 0);
    check("bp_idle", out_valid, 0);

    // Reset with two ops in flight; the first sets the stored carry
    out_ready = 1'b0;
    a = 8'hFF; b = 8'h01; op = OP_ADD_RCA; chain = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h10; op = OP_ADD_RCA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready_after", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_output", out_valid, 0);
    run_single("post_rst_chain", 8'h05, 8'h03, OP_ADD_RCA, 1'b1, 8'h08, 1'b0);

    // Random traffic with random stalls
    repeat (1500) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = W'($urandom);
        b = W'($urandom);
        op = 3'($urandom_range(0, 7));
        chain = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_drained", q.size(), 0);
    check("rand_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
